// File: rtl/data_ram_pkg.sv
// Shared constants and types for the data-memory responder.
// Word width, default geometry and FSM state encoding.
package data_ram_pkg;

    localparam int WORD_W    = 32;
    localparam int DEPTH_DEF = 256;
    localparam int AW_DEF    = 8;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/data_ram_responder_word_ram.sv
// Word-addressed storage: one synchronous write port,
// one asynchronous read port.
module word_ram
    import data_ram_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Single write port, committed at the clock edge
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_ram_responder.sv
// Data-memory responder: clears the array, optionally takes a
// boot image, then serves the core's MEM-stage accesses.
module data_ram_responder
    import data_ram_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AW        = AW_DEF,
    parameter int BOOT_LOAD = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [WORD_W-1:0] ram_in_address,
    input  logic [WORD_W-1:0] ram_in_data,
    input  logic              ram_in_write,
    output logic [WORD_W-1:0] ram_out,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [AW-1:0]     load_addr,
    input  logic [WORD_W-1:0] load_data,
    input  logic              load_last,
    output logic              core_hold,
    output logic              oob_error
);

    state_t            state;
    state_t            next_state;
    logic [AW-1:0]     clr_cnt;
    logic [AW-1:0]     idx;
    logic              in_range;
    logic              beat;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;

    assign idx        = ram_in_address[AW-1:0];
    assign in_range   = (ram_in_address[WORD_W-1:AW] == '0);
    assign load_ready = (state == LOAD);
    assign beat       = load_valid && load_ready;

    // Next-state: sweep the array, then take the image, then run
    always_comb begin
        next_state = state;
        unique case (state)
            CLEAR: begin
                if (clr_cnt == AW'(DEPTH - 1)) begin
                    next_state = (BOOT_LOAD != 0) ? LOAD : RUN;
                end
            end
            LOAD: begin
                if (beat && load_last) begin
                    next_state = RUN;
                end
            end
            RUN:     next_state = RUN;
            default: next_state = CLEAR;
        endcase
    end

    // State, sweep counter, core hold and sticky range error
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            core_hold <= 1'b1;
            oob_error <= 1'b0;
        end else begin
            state     <= next_state;
            core_hold <= (next_state != RUN);
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + AW'(1);
            end
            if (state == RUN && !in_range) begin
                oob_error <= 1'b1;
            end
        end
    end

    // Write-source mux: only one source is live in each state
    always_comb begin
        we    = 1'b0;
        waddr = idx;
        wdata = ram_in_data;
        if (!clr) begin
            unique case (state)
                CLEAR: begin
                    we    = 1'b1;
                    waddr = clr_cnt;
                    wdata = '0;
                end
                LOAD: begin
                    we    = beat;
                    waddr = load_addr;
                    wdata = load_data;
                end
                RUN: begin
                    we = ram_in_write && in_range;
                end
                default: ;
            endcase
        end
    end

    word_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (idx),
        .rdata (rdata)
    );

    assign ram_out = (state == RUN && in_range) ? rdata : '0;

endmodule

// File: tb/tb_data_ram_responder.sv
// Testbench for data_ram_responder: scoreboard against a
// behavioural memory model, plus a no-boot-load instance.
module tb_data_ram_responder;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        hold;
        logic        rdy;
        logic        oob;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic        wr;
    logic [31:0] rout;
    logic        lv;
    logic        lr;
    logic [3:0]  la;
    logic [31:0] ld;
    logic        ll;
    logic        hold;
    logic        oob;

    logic        n_clr;
    logic [31:0] n_addr;
    logic [31:0] n_wdat;
    logic        n_wr;
    logic [31:0] n_rout;
    logic        n_lv;
    logic        n_lr;
    logic [3:0]  n_la;
    logic [31:0] n_ld;
    logic        n_ll;
    logic        n_hold;
    logic        n_oob;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mdl [DEPTH];
    logic        moob;
    exp_t        sb [$];

    always #5 clk = ~clk;

    data_ram_responder #(
        .DEPTH(DEPTH), .AW(AW), .BOOT_LOAD(1)
    ) dut (
        .clk(clk), .clr(clr),
        .ram_in_address(addr), .ram_in_data(wdat),
        .ram_in_write(wr), .ram_out(rout),
        .load_valid(lv), .load_ready(lr),
        .load_addr(la), .load_data(ld), .load_last(ll),
        .core_hold(hold), .oob_error(oob)
    );

    data_ram_responder #(
        .DEPTH(DEPTH), .AW(AW), .BOOT_LOAD(0)
    ) nb (
        .clk(clk), .clr(n_clr),
        .ram_in_address(n_addr), .ram_in_data(n_wdat),
        .ram_in_write(n_wr), .ram_out(n_rout),
        .load_valid(n_lv), .load_ready(n_lr),
        .load_addr(n_la), .load_data(n_ld), .load_last(n_ll),
        .core_hold(n_hold), .oob_error(n_oob)
    );

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", n, act, exp);
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, ".ram_out"}, rout, e.rd);
            chk({e.name, ".core_hold"}, 32'(hold), 32'(e.hold));
            chk({e.name, ".load_ready"}, 32'(lr), 32'(e.rdy));
            chk({e.name, ".oob_error"}, 32'(oob), 32'(e.oob));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(string n, logic [31:0] r, logic h, logic y);
        exp_t e;
        e.name = n;
        e.rd   = r;
        e.hold = h;
        e.rdy  = y;
        e.oob  = moob;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 5) == 0) return $urandom | 32'h10;
        return 32'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        moob = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        lv  = 1'b0;
        wr  = 1'b0;
        tick();
        clr = 1'b0;
        zero_model();
    endtask

    // Array is being swept: core stores must be ignored
    task automatic clear_phase();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 3) begin
                addr = 32'd2;
                wdat = 32'hFFFF_FFFF;
            end else begin
                addr = rnd_addr();
                wdat = $urandom;
            end
            wr = 1'b1;
            push($sformatf("clear%0d", i), 32'h0, 1'b1, 1'b0);
            tick();
        end
        wr = 1'b0;
    endtask

    task automatic send_beat(logic [3:0] a, logic [31:0] d, logic last);
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
            lv   = 1'b0;
            addr = rnd_addr();
            wdat = $urandom;
            wr   = 1'b1;
            push("load_idle", 32'h0, 1'b1, 1'b1);
            tick();
        end
        lv = 1'b1;
        la = a;
        ld = d;
        ll = last;
        wr = 1'b0;
        push($sformatf("beat@%0d", a), 32'h0, 1'b1, 1'b1);
        tick();
        mdl[a] = d;
        lv = 1'b0;
        ll = 1'b0;
    endtask

    task automatic run_cycle(logic [31:0] a, logic [31:0] d, logic w);
        logic ok;
        ok   = (a[31:4] == '0);
        addr = a;
        wdat = d;
        wr   = w;
        push($sformatf("run@%h", a), ok ? mdl[a[3:0]] : 32'h0, 1'b0, 1'b0);
        tick();
        if (ok && w) mdl[a[3:0]] = d;
        if (!ok) moob = 1'b1;
        wr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        clr = 1'b1; addr = '0; wdat = '0; wr = 1'b0;
        lv = 1'b0; la = '0; ld = '0; ll = 1'b0;
        n_clr = 1'b1; n_addr = '0; n_wdat = '0; n_wr = 1'b0;
        n_lv = 1'b0; n_la = '0; n_ld = '0; n_ll = 1'b0;
        zero_model();

        // No-boot instance: hold lasts exactly DEPTH cycles
        tick();
        n_clr = 1'b0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            @(negedge clk);
            chk($sformatf("nb_hold%0d", i), 32'(n_hold),
                (i < DEPTH) ? 32'd1 : 32'd0);
            chk($sformatf("nb_ready%0d", i), 32'(n_lr), 32'd0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_addr = 32'(i);
            #1;
            chk($sformatf("nb_zero%0d", i), n_rout, 32'h0);
        end
        chk("nb_oob", 32'(n_oob), 32'd0);

        // Boot-load instance: clear, image, directed RUN checks
        tick();
        do_clr();
        clear_phase();
        send_beat(4'd3, 32'hDEAD_BEEF, 1'b0);
        send_beat(4'd7, 32'h1234_5678, 1'b1);
        run_cycle(32'd3, $urandom, 1'b0);
        run_cycle(32'd7, $urandom, 1'b0);
        run_cycle(32'd5, $urandom, 1'b0);
        run_cycle(32'd2, $urandom, 1'b0);
        run_cycle(32'd4, 32'hA5A5_A5A5, 1'b1);
        run_cycle(32'd4, $urandom, 1'b0);
        run_cycle(32'h10, 32'h7777_7777, 1'b1);
        run_cycle(32'd0, $urandom, 1'b0);
        run_cycle(32'd1, $urandom, 1'b0);
        for (int i = 0; i < 150; i++) begin
            run_cycle(rnd_addr(), $urandom, 1'($urandom_range(0, 1)));
        end

        // Reset mid-image: partial beat and sticky error vanish
        do_clr();
        clear_phase();
        send_beat(4'd9, 32'hCAFE_F00D, 1'b0);
        clr = 1'b1;
        lv  = 1'b1;
        la  = 4'd10;
        ld  = 32'hBADC_0DE5;
        ll  = 1'b1;
        push("clr_in_load", 32'h0, 1'b1, 1'b1);
        tick();
        clr = 1'b0;
        lv  = 1'b0;
        ll  = 1'b0;
        zero_model();
        clear_phase();
        for (int b = 0; b < 5; b++) begin
            send_beat(4'($urandom_range(0, DEPTH - 1)), $urandom,
                      (b == 4) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            run_cycle(32'(i), $urandom, 1'b0);
        end
        for (int i = 0; i < 60; i++) begin
            run_cycle(rnd_addr(), $urandom, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
- Responder end of the core's data-memory port. Receives RAM_IN_ADDRESS, RAM_IN_DATA and RAM_IN_WRITE from the pipeline's MEM stage and returns RAM_OUT in time for MEMWB capture.
- Owns a word-addressed storage array.
- Zero-fills the array after reset, then optionally accepts a boot image over a valid/ready load port.
- Holds the core in reset (core_hold) until the array is ready for RUN.

Parameters:
DEPTH, 256, number of 32-bit words; power of two, minimum 4
AW, 8, index width; equals log2(DEPTH)
BOOT_LOAD, 1, 1 = enter LOAD after CLEAR; 0 = go directly to RUN

Ports:
clk  in  1  system clock, rising edge
clr  in  1  synchronous active-high reset
ram_in_address  in  32  word address from the core's MEM stage
ram_in_data  in  32  store data from the core
ram_in_write  in  1  store strobe from the core
ram_out  out  32  load data returned to the core
load_valid  in  1  boot-image beat valid
load_ready  out  1  responder can accept a beat
load_addr  in  AW  word index of the beat
load_data  in  32  beat data
load_last  in  1  final beat of the image
core_hold  out  1  1 = core must be held in clr; top level ORs this into the core reset
oob_error  out  1  sticky flag: core accessed an address outside the array

Behaviour:
- Reset is synchronous: on a clk edge with clr=1 the block enters CLEAR.
  - clr_cnt=0, oob_error=0, core_hold=1, load_ready=0, ram_out=0.
  - clr asserted in any state, including mid-CLEAR or mid-LOAD, restarts CLEAR from index 0. Any partial image is discarded.
- FSM states: CLEAR, LOAD, RUN.
- CLEAR:
  - Each cycle writes 0 to mem[clr_cnt] and increments clr_cnt.
  - On the cycle clr_cnt==DEPTH-1, the next state is LOAD if BOOT_LOAD=1, otherwise RUN.
  - CLEAR lasts exactly DEPTH cycles.
- LOAD:
  - load_ready=1.
  - A beat is accepted on an edge where load_valid and load_ready are both 1; it writes mem[load_addr]=load_data.
  - An accepted beat with load_last=1 moves the FSM to RUN on that edge; load_ready is 0 from the next cycle.
  - load_valid=0 leaves the FSM in LOAD indefinitely. Repeated load_addr values overwrite (last beat wins).
- RUN:
  - core_hold=0, load_ready=0.
  - Index = ram_in_address[AW-1:0]. The access is in range when ram_in_address[31:AW]==0.
  - Read is combinational: in range, ram_out=mem[index]; out of range, ram_out=0.
  - Write: in range with ram_in_write=1, mem[index]<=ram_in_data at the edge. Out of range, the write is dropped.
  - Any out-of-range cycle (read or write) sets oob_error on the next edge; it stays set until clr.
  - A read and a write to the same index in the same cycle return the old contents; the new value is visible from the next cycle.
- Outside RUN: core-port writes are ignored, ram_out=0, oob_error does not update.
- core_hold is registered. It is 1 in CLEAR and LOAD and drops on the first RUN cycle.
- The storage array has a single write port with priority CLEAR > LOAD > core. Only one of these sources is active in any state.

Decomposition:
- Package data_ram_pkg holds:
  - WORD_W=32
  - state enum CLEAR=2'd0, LOAD=2'd1, RUN=2'd2
  - the default DEPTH/AW constants
- Sub-module word_ram (DEPTH, AW): one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- Top-level data_ram_responder contains the FSM, clr_cnt, write-source mux, range check and oob_error.

Test Plan:
- DEPTH=16, BOOT_LOAD=0, clr for 1 cycle:
  - core_hold=1 for exactly 16 cycles, then 0.
  - Every address 0..15 reads 0.
- BOOT_LOAD=1, after CLEAR, beats (3,0xDEADBEEF), (7,0x12345678 with load_last):
  - load_ready falls after the last beat.
  - RUN read addr 3 → 0xDEADBEEF, addr 7 → 0x12345678, addr 5 → 0.
- RUN, write addr 4 data 0xA5A5A5A5 while reading addr 4 in the same cycle:
  - ram_out=old value (0) that cycle, 0xA5A5A5A5 the next cycle.
- RUN, access address 0x00000010 (DEPTH=16):
  - ram_out=0, mem[0] unchanged, oob_error=1 from the next edge and stays 1.
- Assert clr mid-LOAD after 1 of 3 beats:
  - CLEAR restarts, the beat is erased (reads 0), oob_error=0.
- During CLEAR, drive ram_in_write=1 to addr 2 with data 0xFFFFFFFF:
  - Write ignored; addr 2 reads 0 in RUN.
